// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, pipeline register layouts
// and the register-operand usage rules used by hazard detection.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
    logic [31:0]        inst;
  } ifid_t;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RV_XLEN-1:0] imm;
  } idex_t;

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_RTYPE, OPC_STORE, OPC_BRANCH, OPC_LOAD, OPC_ITYPE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_RTYPE, OPC_STORE, OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_Gen.sv
// Immediate generator: selects the RV32I immediate format from the opcode and
// sign-extends with inst[31] up to XLEN.
module imm_Gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (inst[6:0])
      OPC_LOAD, OPC_ITYPE, OPC_JALR:
        imm32 = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {inst[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  // Signed cast keeps the sign fill correct if XLEN is ever widened past 32.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage_ctrl.sv
// Decode stage: owns IF/ID and ID/EX, inserts load-use bubbles, honours EX
// back-pressure and kills wrong-path work on flush.
module decode_stage_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_inst,
  output logic             if_ready,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [6:0]       id_opcode,
  output logic [4:0]       id_rd,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [2:0]       id_funct3,
  output logic [6:0]       id_funct7,
  output logic [XLEN-1:0]  id_imm,
  output logic             id_is_load,
  output logic [CNT_W-1:0] stall_count
);

  ifid_t              ifid_q, ifid_d;
  idex_t              idex_q, idex_d;
  idex_t              dec;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RV_XLEN-1:0] imm_w;
  logic               rs1_hit, rs2_hit, hazard;

  imm_Gen #(.XLEN(RV_XLEN)) u_imm_gen (
    .inst (ifid_q.inst),
    .imm  (imm_w)
  );

  always_comb begin
    dec        = '0;
    dec.valid  = ifid_q.valid;
    dec.pc     = ifid_q.pc;
    dec.opcode = ifid_q.inst[6:0];
    dec.rd     = ifid_q.inst[11:7];
    dec.funct3 = ifid_q.inst[14:12];
    dec.rs1    = ifid_q.inst[19:15];
    dec.rs2    = ifid_q.inst[24:20];
    dec.funct7 = ifid_q.inst[31:25];
    dec.imm    = imm_w;
  end

  // A load in ID/EX whose rd feeds the instruction waiting in IF/ID.
  assign rs1_hit = uses_rs1(dec.opcode) && (dec.rs1 == idex_q.rd);
  assign rs2_hit = uses_rs2(dec.opcode) && (dec.rs2 == idex_q.rd);
  assign hazard  = (HAZARD_EN != 0) && ifid_q.valid && idex_q.valid &&
                   (idex_q.opcode == OPC_LOAD) && (idex_q.rd != 5'd0) &&
                   (rs1_hit || rs2_hit);

  // Handshake: fetch word is taken at the clock edge only when if_valid and
  // if_ready are both high; if_ready never looks at if_valid.
  always_comb begin
    ifid_d   = ifid_q;
    idex_d   = idex_q;
    cnt_d    = cnt_q;
    if_ready = 1'b1;
    if (flush) begin
      ifid_d.valid = 1'b0;
      idex_d.valid = 1'b0;
    end else if (ex_stall) begin
      if_ready = 1'b0;
    end else if (hazard) begin
      idex_d       = dec;
      idex_d.valid = 1'b0;
      if_ready     = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      idex_d       = dec;
      ifid_d.valid = if_valid;
      ifid_d.pc    = RV_XLEN'(if_pc);
      ifid_d.inst  = if_inst;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_q <= '0;
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      ifid_q <= ifid_d;
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign id_valid    = idex_q.valid;
  assign id_pc       = XLEN'(idex_q.pc);
  assign id_opcode   = idex_q.opcode;
  assign id_rd       = idex_q.rd;
  assign id_rs1      = idex_q.rs1;
  assign id_rs2      = idex_q.rs2;
  assign id_funct3   = idex_q.funct3;
  assign id_funct7   = idex_q.funct7;
  assign id_imm      = XLEN'(idex_q.imm);
  assign id_is_load  = (idex_q.opcode == OPC_LOAD);
  assign stall_count = cnt_q;

endmodule

// File: doc/decode_stage_ctrl.md
Name: decode_stage_ctrl

Overview:
Decode-stage sequencer for the pipelined RV32I core. It owns the IF/ID and ID/EX pipeline registers and decodes register fields. It builds the immediate through an imm_Gen instance. It detects load-use hazards and inserts a bubble, applies downstream back-pressure, and kills wrong-path instructions on branch/jump flush.

Parameters:
XLEN, 32, datapath and PC width
CNT_W, 16, width of saturating stall counter
HAZARD_EN, 1, 1 enables load-use detection; 0 disables it (bench bypass)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
if_valid  in  1  fetch presents an instruction
if_pc  in  XLEN  PC of fetched instruction
if_inst  in  32  fetched instruction word
if_ready  out  1  decode accepts fetch this cycle
flush  in  1  branch/jump resolved taken in EX; kill younger instructions
ex_stall  in  1  EX cannot accept; hold decode state
id_valid  out  1  ID/EX register holds a real instruction
id_pc  out  XLEN  registered PC
id_opcode  out  7  inst[6:0]
id_rd  out  5  inst[11:7]
id_rs1  out  5  inst[19:15]
id_rs2  out  5  inst[24:20]
id_funct3  out  3  inst[14:12]
id_funct7  out  7  inst[31:25]
id_imm  out  XLEN  immediate from imm_Gen
id_is_load  out  1  id_opcode == 0000011
stall_count  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, any time, including mid-stall): IF/ID and ID/EX valid = 0, all data regs = 0, stall_count = 0. if_ready = 1 while reset deasserted and no stall.
- Latency: instruction accepted at edge N is in IF/ID. At edge N+1 it is on id_* with id_valid = 1, absent stalls.
- rs usage by IF/ID opcode:
  - R-type 0110011, store 0100011, branch 1100011: rs1 and rs2
  - load 0000011, I-ALU 0010011: rs1 only
  - LUI 0110111, JAL 1101111, unknown opcodes: none
- hazard = HAZARD_EN & ifid_valid & id_valid & id_is_load & (id_rd != 0) & (id_rd matches a used rs of IF/ID).
- Per-cycle priority, highest first:
  1. flush: ifid_valid <= 0, id_valid <= 0. if_ready = 1 and the incoming word is dropped. This overrides ex_stall and hazard in the same cycle.
  2. ex_stall: both registers hold, if_ready = 0, stall_count unchanged.
  3. hazard: id_valid <= 0 (bubble; ID/EX data may update but is ignored). IF/ID holds, if_ready = 0, stall_count += 1, saturating at all-ones. The hazard clears on the next cycle because id_valid is 0.
  4. normal: ID/EX <= decode(IF/ID) with id_valid <= ifid_valid. IF/ID <= {if_pc, if_inst} with ifid_valid <= if_valid. if_ready = 1.
- if_ready is combinational from flush, ex_stall and hazard only; it does not depend on if_valid.
- id_imm: sign-extension fills every bit above the encoded sign with inst[31]. Negative immediates must have all upper bits set.
- Bubble outputs: when id_valid = 0, the other id_* values are don't-care but must not be X after reset.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_ITYPE, OPC_LUI, OPC_JAL
  - typedef struct ifid_t {valid, pc, inst}
  - typedef struct idex_t {valid, pc, opcode, rd, rs1, rs2, funct3, funct7, imm}
  - function uses_rs1/uses_rs2(opcode)
- One sub-module: imm_Gen (existing), instantiated on the IF/ID instruction. Everything else stays in decode_stage_ctrl.

Test Plan:
- Assert reset while a hazard bubble is pending -> next cycle id_valid=0, if_ready=1, stall_count=0.
- addi x1,x0,5 (0x00500093) at pc 0x0, no stalls -> two edges later id_valid=1, id_pc=0, id_rd=1, id_rs1=0, id_imm=0x00000005.
- lw x5,0(x2) (0x00012283) then add x6,x5,x7 (0x00728333) -> one cycle with id_valid=0 and if_ready=0. stall_count=1. Next cycle id_rd=6; no further bubble.
- lw x0,0(x2) (0x00012003) then add x6,x0,x7 -> no bubble; stall_count stays 0. Repeat with HAZARD_EN=0 on the x5 case -> no bubble.
- beq x0,x0,-8 (0xFE000CE3) -> id_imm=0xFFFFFFF8. Then flush=1 together with ex_stall=1 and a pending hazard -> next cycle id_valid=0, ifid empty, if_ready=1 during flush.
- ex_stall held 3 cycles mid-stream -> id_* and IF/ID unchanged, if_ready=0. Force stall_count to 0xFFFF via repeated hazards -> stays 0xFFFF.
